ram_fill_responder: RTL and testbench

- Memory-side responder for the cache's RAM request interface; serves line-fill reads and write-back writes.
- Handles one request at a time with a parameterised access latency.
- Supports indirect addressing: the addressed word is used as the effective address.
- Sits below the direct-mapped cache inside the memory module, replacing the bare data RAM.

---
 rtl/ram_resp_pkg.sv | 23 ++
 rtl/ram_fill_responder_ram_array.sv | 25 ++
 rtl/ram_fill_responder.sv | 111 +++++++++++
 tb/tb_ram_fill_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_resp_pkg.sv
// Shared types and elaboration helpers for the RAM fill responder.
package ram_resp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PTR    = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } respState;

    // Smallest legal access latency; zero would leave no cycle to drive the port.
    localparam int unsigned minLatency = 1;

    function automatic bit latencyValid(input int unsigned lat);
        return lat >= minLatency;
    endfunction

    // Counter width needed to hold values 0..lat.
    function automatic int cntWidth(input int unsigned lat);
        return (lat == 0) ? 1 : $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/ram_fill_responder_ram_array.sv
// Single-port storage: synchronous write, combinational read on the shared address.
module ram_array #(
    parameter int unsigned ramWidth = 8,
    parameter int unsigned addrSize = 8
) (
    input  logic                clk,
    input  logic                we,
    input  logic [addrSize-1:0] addr,
    input  logic [ramWidth-1:0] din,
    output logic [ramWidth-1:0] readDataC
);

    localparam int unsigned depth = 2 ** addrSize;

    logic [ramWidth-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
    end

    assign readDataC = mem[addr];

endmodule

// File: rtl/ram_fill_responder.sv
// Memory-side responder for line fills and write-backs, with optional pointer indirection.
module ram_fill_responder
    import ram_resp_pkg::*;
#(
    parameter int unsigned ramWidth      = 8,
    parameter int unsigned addrSize      = 8,
    parameter int unsigned accessLatency = 2
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                reqValid,
    input  logic                reqWrite,
    input  logic                isIndirect,
    input  logic [addrSize-1:0] reqAddr,
    input  logic [ramWidth-1:0] dataIn,
    output logic                busy,
    output logic                dataReady,
    output logic [ramWidth-1:0] dataOut
);

    if (!latencyValid(accessLatency)) begin : gBadLatency
        $error("ram_fill_responder: accessLatency must be at least 1");
    end

    localparam int unsigned cntW = cntWidth(accessLatency);
    localparam logic [cntW-1:0] cntLoad = cntW'(accessLatency - 1);

    respState            state;
    logic [cntW-1:0]     cnt;
    logic [addrSize-1:0] capAddr;
    logic [addrSize-1:0] effAddr;
    logic [ramWidth-1:0] capData;
    logic                capWrite;

    logic [addrSize-1:0] ramAddr;
    logic [ramWidth-1:0] ramData;
    logic [addrSize-1:0] ptrAddr;
    logic                ramWe;

    // PTR reads the pointer cell; ACCESS reads or writes the effective address.
    assign ramAddr = (state == PTR) ? capAddr : effAddr;
    assign ptrAddr = addrSize'(ramData);
    assign ramWe   = (state == ACCESS) && (cnt == '0) && capWrite;

    ram_array #(
        .ramWidth(ramWidth),
        .addrSize(addrSize)
    ) uArray (
        .clk      (clk),
        .we       (ramWe),
        .addr     (ramAddr),
        .din      (capData),
        .readDataC(ramData)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= IDLE;
            cnt       <= '0;
            capAddr   <= '0;
            effAddr   <= '0;
            capData   <= '0;
            capWrite  <= 1'b0;
            busy      <= 1'b0;
            dataReady <= 1'b0;
            dataOut   <= '0;
        end else begin
            dataReady <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (reqValid) begin
                        capAddr  <= reqAddr;
                        effAddr  <= reqAddr;
                        capData  <= dataIn;
                        capWrite <= reqWrite;
                        cnt      <= cntLoad;
                        busy     <= 1'b1;
                        state    <= isIndirect ? PTR : ACCESS;
                    end
                end
                PTR: begin
                    if (cnt == '0) begin
                        effAddr <= ptrAddr;
                        cnt     <= cntLoad;
                        state   <= ACCESS;
                    end else begin
                        cnt <= cnt - cntW'(1);
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!capWrite) begin
                            dataOut <= ramData;
                        end
                        dataReady <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - cntW'(1);
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_fill_responder.sv
// Randomized bench for ram_fill_responder against a request-level timing/memory model.
module tb_ram_fill_responder;

    localparam int unsigned LAT = 2;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       reqValid = 1'b0;
    logic       reqWrite = 1'b0;
    logic       isIndirect = 1'b0;
    logic [7:0] reqAddr = '0;
    logic [7:0] dataIn = '0;
    logic       busy;
    logic       dataReady;
    logic [7:0] dataOut;

    logic       u1Valid = 1'b0;
    logic       u1Write = 1'b0;
    logic       u1Ind = 1'b0;
    logic [7:0] u1Addr = '0;
    logic [7:0] u1Din = '0;
    logic       u1Busy;
    logic       u1Ready;
    logic [7:0] u1Out;

    int passCnt = 0;
    int totalCnt = 0;

    always #5 clk = ~clk;

    ram_fill_responder #(.ramWidth(8), .addrSize(8), .accessLatency(LAT)) dut (
        .clk(clk), .clr(clr), .reqValid(reqValid), .reqWrite(reqWrite),
        .isIndirect(isIndirect), .reqAddr(reqAddr), .dataIn(dataIn),
        .busy(busy), .dataReady(dataReady), .dataOut(dataOut)
    );

    ram_fill_responder #(.ramWidth(8), .addrSize(8), .accessLatency(1)) dut1 (
        .clk(clk), .clr(clr), .reqValid(u1Valid), .reqWrite(u1Write),
        .isIndirect(u1Ind), .reqAddr(u1Addr), .dataIn(u1Din),
        .busy(u1Busy), .dataReady(u1Ready), .dataOut(u1Out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Request-level model: a request accepted at edge e completes at edge e+L (direct)
    // or e+2L (indirect); the following edge returns to idle.
    logic [7:0] mMem [256];
    int         phase = 0;
    int         edgeCnt = 0;
    int         doneEdge = 0;
    bit         mWrite;
    logic [7:0] mEff, mData;
    logic       expBusy = 1'b0, expReady = 1'b0;
    logic [7:0] expOut = '0;
    int         acceptCnt = 0;
    int         readyCnt = 0;

    always @(posedge clk) begin
        if (clr) begin
            phase = 0; expBusy = 1'b0; expReady = 1'b0; expOut = '0;
        end else begin
            case (phase)
                0: if (reqValid) begin
                    mWrite   = reqWrite;
                    mData    = dataIn;
                    mEff     = isIndirect ? mMem[reqAddr] : reqAddr;
                    doneEdge = edgeCnt + (isIndirect ? 2 * LAT : LAT);
                    phase    = 1;
                    expBusy  = 1'b1;
                    acceptCnt++;
                end
                1: if (edgeCnt == doneEdge) begin
                    if (mWrite) mMem[mEff] = mData;
                    else expOut = mMem[mEff];
                    phase = 2;
                    expReady = 1'b1;
                end
                default: begin
                    phase = 0; expBusy = 1'b0; expReady = 1'b0;
                end
            endcase
        end
        edgeCnt++;
        #1;
        chk("busy", busy, expBusy);
        chk("dataReady", dataReady, expReady);
        chk("dataOut", dataOut, expOut);
        if (dataReady) readyCnt++;
    end

    task automatic waitIdle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle wait", busy, 0);
    endtask

    // Issue one request at a negedge and measure the completion cycle (accept edge = 0).
    task automatic doReq(input bit wr, input bit ind, input logic [7:0] addr,
                         input logic [7:0] din, input int expCyc,
                         input logic [7:0] expData, input string name);
        int cyc;
        waitIdle();
        reqValid = 1'b1; reqWrite = wr; isIndirect = ind; reqAddr = addr; dataIn = din;
        @(posedge clk); #1;
        reqValid = 1'b0;
        cyc = 1;
        while (!dataReady && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " cycle"}, cyc, expCyc);
        chk({name, " data"}, dataOut, expData);
    endtask

    initial begin
        int a0, r0, rc1, rc2;
        logic [7:0] o1, o2;

        repeat (3) @(negedge clk);
        chk("reset busy", busy, 0);
        chk("reset dataReady", dataReady, 0);
        chk("reset dataOut", dataOut, 0);
        clr = 1'b0;

        // Fill storage so every later read has a known value.
        for (int i = 0; i < 256; i++)
            doReq(1'b1, 1'b0, 8'(i), 8'($urandom), LAT + 1, 8'h00, "fill");

        doReq(1'b1, 1'b0, 8'h10, 8'hA5, 3, 8'h00, "direct write");
        doReq(1'b0, 1'b0, 8'h10, 8'h00, 3, 8'hA5, "direct read");
        doReq(1'b1, 1'b0, 8'h20, 8'h30, 3, 8'hA5, "ptr preload");
        doReq(1'b1, 1'b0, 8'h30, 8'h5C, 3, 8'hA5, "target preload");
        doReq(1'b0, 1'b1, 8'h20, 8'h00, 5, 8'h5C, "indirect read");

        // Abort a write during ACCESS; reqValid stays high through reset.
        doReq(1'b1, 1'b0, 8'h40, 8'h11, 3, 8'h5C, "abort preload");
        waitIdle();
        reqValid = 1'b1; reqWrite = 1'b1; isIndirect = 1'b0; reqAddr = 8'h40; dataIn = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort dataReady", dataReady, 0);
        chk("abort dataOut", dataOut, 0);
        repeat (2) @(negedge clk);
        clr = 1'b0; reqValid = 1'b0;
        repeat (3) @(negedge clk);
        doReq(1'b0, 1'b0, 8'h40, 8'h00, 3, 8'h11, "post-abort read");

        // Held request with a changing address: one accept per idle visit.
        waitIdle();
        a0 = acceptCnt; r0 = readyCnt;
        reqValid = 1'b1; reqWrite = 1'b0; isIndirect = 1'b0; reqAddr = 8'h01;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            reqAddr = 8'((k + 1) % 4 + 1);
        end
        reqValid = 1'b0;
        repeat (8) @(negedge clk);
        chk("held accepts", acceptCnt - a0, 5);
        chk("held readies", readyCnt - r0, 5);

        // Random traffic with occasional reset pulses.
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            clr        = ($urandom_range(0, 99) == 0);
            reqValid   = ($urandom_range(0, 3) != 0);
            reqWrite   = ($urandom_range(0, 2) == 0);
            isIndirect = $urandom_range(0, 1) == 1;
            reqAddr    = 8'($urandom);
            dataIn     = 8'($urandom);
        end
        @(negedge clk);
        clr = 1'b0; reqValid = 1'b0;
        waitIdle();

        // Latency 1, back-to-back reads of 0x00 and 0x01.
        @(negedge clk);
        u1Valid = 1'b1; u1Write = 1'b1; u1Addr = 8'h00; u1Din = 8'h3C;
        @(posedge clk); #1; u1Valid = 1'b0;
        repeat (4) @(negedge clk);
        u1Valid = 1'b1; u1Write = 1'b1; u1Addr = 8'h01; u1Din = 8'hC3;
        @(posedge clk); #1; u1Valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("L1 idle", u1Busy, 0);
        u1Valid = 1'b1; u1Write = 1'b0; u1Addr = 8'h00;
        @(posedge clk); #1;
        u1Addr = 8'h01;
        rc1 = 0; rc2 = 0; o1 = '0; o2 = '0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            if (cyc > 1) begin
                @(posedge clk); #1;
            end
            if (cyc == 4) u1Valid = 1'b0;
            if (u1Ready) begin
                if (rc1 == 0) begin rc1 = cyc; o1 = u1Out; end
                else if (rc2 == 0) begin rc2 = cyc; o2 = u1Out; end
            end
        end
        chk("L1 first cycle", rc1, 2);
        chk("L1 second cycle", rc2, 5);
        chk("L1 first data", o1, 8'h3C);
        chk("L1 second data", o2, 8'hC3);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
